// File: rtl/adex_neuron_scheduler.sv
// adex_neuron_scheduler
// Shares one AdEx update datapath across N_NEURONS neurons. Each tick starts
// a sweep in index order: a neuron still counting down its refractory period
// is skipped, otherwise its V/w are offered to the datapath, and the returned
// V/w are written back verbatim. Spikes are reported as one-cycle events and
// accumulated in a saturating counter.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   tick                  start a sweep (dropped and flagged as overrun if busy)
//   clr_ovr               clear the sticky overrun flag
//   dp_valid/dp_ready     request handshake to the datapath
//   dp_idx, dp_v, dp_w    neuron index and its current V / w
//   rsp_valid             one-cycle result strobe from the datapath
//   rsp_v, rsp_w          post-update V / w
//   rsp_spike             neuron fired during this update
//   spk_valid, spk_idx    one-cycle spike event and the neuron that fired
//   spk_cnt               saturating total spike count
//   busy                  sweep in progress
//   sweep_done            asserted in the cycle the last neuron completes
//   overrun               sticky: tick arrived while busy
module adex_neuron_scheduler #(
  parameter int                       N_NEURONS = 4,
  parameter int                       DW        = 16,
  parameter logic signed [DW-1:0]     V_INIT    = 16'hB000,
  parameter logic signed [DW-1:0]     W_INIT    = 16'h0000,
  parameter int                       REFRAC    = 2,
  localparam int                      IW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 clr_ovr,
  output logic                 dp_valid,
  input  logic                 dp_ready,
  output logic [IW-1:0]        dp_idx,
  output logic signed [DW-1:0] dp_v,
  output logic signed [DW-1:0] dp_w,
  input  logic                 rsp_valid,
  input  logic signed [DW-1:0] rsp_v,
  input  logic signed [DW-1:0] rsp_w,
  input  logic                 rsp_spike,
  output logic                 spk_valid,
  output logic [IW-1:0]        spk_idx,
  output logic [15:0]          spk_cnt,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 overrun
);

  // Refractory counter must hold REFRAC; keep at least one bit when REFRAC is 0.
  localparam int            RW   = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [DW-1:0]  v_q [N_NEURONS];
  logic signed [DW-1:0]  v_d [N_NEURONS];
  logic signed [DW-1:0]  w_q [N_NEURONS];
  logic signed [DW-1:0]  w_d [N_NEURONS];
  logic [RW-1:0]         refrac_q [N_NEURONS];
  logic [RW-1:0]         refrac_d [N_NEURONS];
  logic                  spk_valid_q, spk_valid_d;
  logic [IW-1:0]         spk_idx_q, spk_idx_d;
  logic [15:0]           spk_cnt_q, spk_cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  advance;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    v_d         = v_q;
    w_d         = w_q;
    refrac_d    = refrac_q;
    spk_valid_d = 1'b0;
    spk_idx_d   = spk_idx_q;
    spk_cnt_d   = spk_cnt_q;
    overrun_d   = overrun_q;
    dp_valid    = 1'b0;
    sweep_done  = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_CHECK;
      end
      S_CHECK: begin
        // A refractory neuron costs one cycle and no datapath request.
        if (refrac_q[idx_q] != '0) begin
          refrac_d[idx_q] = refrac_q[idx_q] - RW'(1);
          advance         = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dp_valid = 1'b1;
        if (dp_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          v_d[idx_q] = rsp_v;
          w_d[idx_q] = rsp_w;
          if (rsp_spike) begin
            spk_valid_d     = 1'b1;
            spk_idx_d       = idx_q;
            refrac_d[idx_q] = RW'(REFRAC);
            spk_cnt_d       = sat_inc(spk_cnt_q);
          end
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST) begin
        idx_d      = '0;
        sweep_done = 1'b1;
        state_d    = S_IDLE;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = S_CHECK;
      end
    end

    // A dropped tick outranks a simultaneous clear.
    if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;
    else if (clr_ovr)                overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= '0;
      spk_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]      <= V_INIT;
        w_q[i]      <= W_INIT;
        refrac_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spk_valid_q <= spk_valid_d;
      spk_idx_q   <= spk_idx_d;
      spk_cnt_q   <= spk_cnt_d;
      overrun_q   <= overrun_d;
      v_q         <= v_d;
      w_q         <= w_d;
      refrac_q    <= refrac_d;
    end
  end

  assign dp_idx    = idx_q;
  assign dp_v      = v_q[idx_q];
  assign dp_w      = w_q[idx_q];
  assign busy      = (state_q != S_IDLE);
  assign spk_valid = spk_valid_q;
  assign spk_idx   = spk_idx_q;
  assign spk_cnt   = spk_cnt_q;
  assign overrun   = overrun_q;

endmodule
